// File: rtl/mem_access_unit.sv
// Serialises byte/half/word loads and stores into single-byte memory cycles.
// Define MAU_UNALIGNED_EN to allow misaligned half/word accesses.
module mem_access_unit #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, XFER, CAPT, RESP} state_t;

    state_t             state, state_n;
    logic [1:0]         idx, idx_n, idx_inc, last_idx;
    logic               lat_write, lat_signed;
    logic [1:0]         lat_size;
    logic [ADDR_W-1:0]  lat_addr;
    logic [DATA_W-1:0]  lat_wdata;
    logic [DATA_W-1:0]  rbuf, rbuf_n;
    logic               accept, illegal;
    logic [ADDR_W-1:0]  mem_addr_n;
    logic [DATA_W-1:0]  mem_wdata_n, resp_rdata_n;
    logic               mem_read_n, mem_write_n, resp_valid_n, resp_err_n;
    logic               unused_rdata;

    assign unused_rdata = ^mem_rdata[DATA_W-1:8];
    assign accept       = (state == IDLE) && req_ready && req_valid;
    assign idx_inc      = idx + 2'd1;

    function automatic logic [7:0] byte_of(input logic [DATA_W-1:0] w, input logic [1:0] i);
        return w[{i, 3'b000} +: 8];
    endfunction

    function automatic logic [DATA_W-1:0] extend(input logic [DATA_W-1:0] d,
                                                 input logic [1:0] sz, input logic sgn);
        case (sz)
            2'b00:   return {{(DATA_W-8){sgn & d[7]}}, d[7:0]};
            2'b01:   return {{(DATA_W-16){sgn & d[15]}}, d[15:0]};
            default: return d;
        endcase
    endfunction

    always_comb begin
`ifdef MAU_UNALIGNED_EN
        illegal = (req_size == 2'b11);
`else
        illegal = (req_size == 2'b11)
               || (req_size == 2'b01 && req_addr[0])
               || (req_size == 2'b10 && req_addr[1:0] != 2'b00);
`endif
    end

    always_comb begin
        case (lat_size)
            2'b00:   last_idx = 2'd0;
            2'b01:   last_idx = 2'd1;
            default: last_idx = 2'd3;
        endcase
    end

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_n      = state;
        idx_n        = idx;
        rbuf_n       = rbuf;
        mem_addr_n   = mem_addr;
        mem_wdata_n  = '0;
        mem_read_n   = 1'b0;
        mem_write_n  = 1'b0;
        resp_valid_n = 1'b0;
        resp_err_n   = 1'b0;
        resp_rdata_n = '0;
        case (state)
            IDLE: begin
                if (accept) begin
                    idx_n = 2'd0;
                    if (illegal) begin
                        state_n      = RESP;
                        resp_valid_n = 1'b1;
                        resp_err_n   = 1'b1;
                    end else begin
                        state_n     = XFER;
                        mem_addr_n  = req_addr;
                        mem_write_n = req_write;
                        mem_read_n  = !req_write;
                        if (req_write)
                            mem_wdata_n = {{(DATA_W-8){1'b0}}, req_wdata[7:0]};
                    end
                end
            end
            XFER: begin
                if (lat_write) begin
                    if (idx == last_idx) begin
                        state_n      = RESP;
                        resp_valid_n = 1'b1;
                    end else begin
                        idx_n       = idx_inc;
                        mem_addr_n  = lat_addr + ADDR_W'(idx_inc);
                        mem_write_n = 1'b1;
                        mem_wdata_n = {{(DATA_W-8){1'b0}}, byte_of(lat_wdata, idx_inc)};
                    end
                end else begin
                    state_n = CAPT;
                end
            end
            CAPT: begin
                // Memory registered the byte on the previous edge; merge it now.
                rbuf_n[{idx, 3'b000} +: 8] = mem_rdata[7:0];
                if (idx == last_idx) begin
                    state_n      = RESP;
                    resp_valid_n = 1'b1;
                    resp_rdata_n = extend(rbuf_n, lat_size, lat_signed);
                end else begin
                    idx_n      = idx_inc;
                    state_n    = XFER;
                    mem_addr_n = lat_addr + ADDR_W'(idx_inc);
                    mem_read_n = 1'b1;
                end
            end
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            idx        <= 2'd0;
            rbuf       <= '0;
            lat_write  <= 1'b0;
            lat_signed <= 1'b0;
            lat_size   <= 2'b00;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            req_ready  <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
        end else begin
            state      <= state_n;
            idx        <= idx_n;
            rbuf       <= rbuf_n;
            req_ready  <= (state_n == IDLE);
            mem_addr   <= mem_addr_n;
            mem_wdata  <= mem_wdata_n;
            mem_read   <= mem_read_n;
            mem_write  <= mem_write_n;
            resp_valid <= resp_valid_n;
            resp_err   <= resp_err_n;
            resp_rdata <= resp_rdata_n;
            if (accept) begin
                lat_write  <= req_write;
                lat_signed <= req_signed;
                lat_size   <= req_size;
                lat_addr   <= req_addr;
                lat_wdata  <= req_wdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: byte-wide memory, transaction-level reference model
// and directed requests. Honours MAU_UNALIGNED_EN when defined.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_write, req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_read, mem_write;
    logic [31:0] mem_rdata;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [7:0] dmem   [logic [31:0]];
    logic [7:0] refmem [logic [31:0]];

    // Reference model state for the request in flight
    logic        m_active = 1'b0, m_ready = 1'b0, m_write, m_err;
    logic [31:0] m_addr, m_wdata, m_rdata;
    int          m_n, m_k;

    mem_access_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
        .mem_write(mem_write), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp)
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        else
            pass_cnt++;
    endtask

    function automatic logic [7:0] ref_byte(input logic [31:0] a);
        return refmem.exists(a) ? refmem[a] : 8'h00;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] a, input int n, input logic sgn);
        logic [31:0] v;
        v = 32'h0;
        for (int i = 0; i < n; i++)
            v = v | (32'(ref_byte(a + 32'(i))) << (8 * i));
        if (sgn && n < 4 && v[8*n-1])
            v = v | ~((32'd1 << (8 * n)) - 32'd1);
        return v;
    endfunction

    // Byte-wide data memory: writes on the strobe edge, read data registered
    initial begin
        mem_rdata = 32'h0;
        forever begin
            @(posedge clk);
            if (mem_write) dmem[mem_addr] = mem_wdata[7:0];
            if (mem_read)
                mem_rdata <= {24'h0, dmem.exists(mem_addr) ? dmem[mem_addr] : 8'h00};
        end
    end

    // Cycle-by-cycle comparison against the transaction schedule
    initial begin : model
        logic exp_rd, exp_wr, exp_rv, ill;
        int   off;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                checkOutput("rst_req_ready", 32'(req_ready), 32'h0);
                checkOutput("rst_mem_read", 32'(mem_read), 32'h0);
                checkOutput("rst_mem_write", 32'(mem_write), 32'h0);
                checkOutput("rst_resp_valid", 32'(resp_valid), 32'h0);
                checkOutput("rst_resp_err", 32'(resp_err), 32'h0);
                checkOutput("rst_resp_rdata", resp_rdata, 32'h0);
                checkOutput("rst_mem_addr", mem_addr, 32'h0);
                checkOutput("rst_mem_wdata", mem_wdata, 32'h0);
                m_active = 1'b0;
                m_ready  = 1'b0;
            end else begin
                exp_rd = 1'b0;
                exp_wr = 1'b0;
                exp_rv = 1'b0;
                off    = 0;
                if (m_active) begin
                    if (m_err) begin
                        exp_rv = (m_k == 1);
                    end else if (m_write) begin
                        exp_wr = (m_k <= m_n);
                        exp_rv = (m_k == m_n + 1);
                        off    = m_k - 1;
                    end else begin
                        exp_rd = (m_k % 2 == 1) && (m_k < 2 * m_n);
                        exp_rv = (m_k == 2 * m_n + 1);
                        off    = (m_k - 1) / 2;
                    end
                end
                checkOutput("req_ready", 32'(req_ready), 32'(m_ready));
                checkOutput("mem_read", 32'(mem_read), 32'(exp_rd));
                checkOutput("mem_write", 32'(mem_write), 32'(exp_wr));
                if (exp_rd || exp_wr)
                    checkOutput("mem_addr", mem_addr, m_addr + 32'(off));
                if (exp_wr)
                    checkOutput("mem_wdata", mem_wdata, (m_wdata >> (8 * off)) & 32'hFF);
                checkOutput("resp_valid", 32'(resp_valid), 32'(exp_rv));
                if (exp_rv) begin
                    checkOutput("resp_err", 32'(resp_err), 32'(m_err));
                    checkOutput("resp_rdata", resp_rdata, m_rdata);
                end

                if (m_active) begin
                    if (exp_rv) begin
                        m_active = 1'b0;
                        m_ready  = 1'b1;
                    end else begin
                        m_k++;
                    end
                end else if (req_valid && m_ready) begin
                    m_write = req_write;
                    m_addr  = req_addr;
                    m_wdata = req_wdata;
                    m_n     = (req_size == 2'b00) ? 1 : (req_size == 2'b01) ? 2 : 4;
`ifdef MAU_UNALIGNED_EN
                    ill = (req_size == 2'b11);
`else
                    ill = (req_size == 2'b11) || (req_size == 2'b01 && req_addr[0])
                       || (req_size == 2'b10 && req_addr[1:0] != 2'b00);
`endif
                    m_err = ill;
                    if (!ill && req_write)
                        for (int i = 0; i < m_n; i++)
                            refmem[req_addr + 32'(i)] = 8'((req_wdata >> (8 * i)) & 32'hFF);
                    m_rdata  = (ill || req_write) ? 32'h0 : model_load(req_addr, m_n, req_signed);
                    m_active = 1'b1;
                    m_k      = 1;
                    m_ready  = 1'b0;
                end else begin
                    m_ready = 1'b1;
                end
            end
        end
    end

    task automatic sendRequest(input logic wr, input logic [1:0] sz, input logic sg,
                               input logic [31:0] addr, input logic [31:0] wd);
        logic r, accepted;
        req_valid  = 1'b1;
        req_write  = wr;
        req_size   = sz;
        req_signed = sg;
        req_addr   = addr;
        req_wdata  = wd;
        accepted   = 1'b0;
        for (int c = 0; c < 40 && !accepted; c++) begin
            @(negedge clk);
            r = req_ready;
            @(posedge clk);
            if (r) accepted = 1'b1;
        end
        #1;
        req_valid  = 1'b0;
        req_write  = ~wr;
        req_size   = ~sz;
        req_signed = ~sg;
        req_addr   = 32'hDEAD_BEEF;
        req_wdata  = $urandom;
        if (!accepted) checkOutput("accept_timeout", 32'h0, 32'h1);
    endtask

    task automatic applyStimulus(input logic wr, input logic [1:0] sz, input logic sg,
                                 input logic [31:0] addr, input logic [31:0] wd, input string tag,
                                 input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat);
        int          lat;
        logic        got;
        logic [31:0] rd;
        logic        er;
        sendRequest(wr, sz, sg, addr, wd);
        lat = 0;
        got = 1'b0;
        rd  = 32'h0;
        er  = 1'b0;
        for (int c = 0; c < 40 && !got; c++) begin
            @(negedge clk);
            lat++;
            if (resp_valid) begin
                got = 1'b1;
                rd  = resp_rdata;
                er  = resp_err;
            end
        end
        if (!got) begin
            checkOutput({tag, "_timeout"}, 32'h0, 32'h1);
        end else begin
            checkOutput({tag, "_lat"}, 32'(lat), 32'(exp_lat));
            checkOutput({tag, "_rdata"}, rd, exp_rdata);
            checkOutput({tag, "_err"}, 32'(er), 32'(exp_err));
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] global timeout");
    end

    initial begin
        rst_n = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_signed = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_ready", 32'(req_ready), 32'h0);
        checkOutput("reset_mem_addr", mem_addr, 32'h0);
        rst_n = 1'b1;
        #1;
        checkOutput("ready_before_edge", 32'(req_ready), 32'h0);
        @(posedge clk);
        #1;
        checkOutput("ready_after_edge", 32'(req_ready), 32'h1);

        applyStimulus(1, 2'b10, 0, 32'h20, 32'hA1B2C3D4, "st_word_20", 32'h0, 0, 5);
        applyStimulus(0, 2'b10, 0, 32'h20, 32'h0, "ld_word_20", 32'hA1B2C3D4, 0, 9);
        applyStimulus(1, 2'b00, 0, 32'h30, 32'h12345680, "st_byte_30", 32'h0, 0, 2);
        applyStimulus(0, 2'b00, 1, 32'h30, 32'h0, "ld_sbyte_30", 32'hFFFFFF80, 0, 3);
        applyStimulus(0, 2'b00, 0, 32'h30, 32'h0, "ld_ubyte_30", 32'h00000080, 0, 3);
        applyStimulus(1, 2'b00, 0, 32'h32, 32'h0000007F, "st_byte_32", 32'h0, 0, 2);
`ifdef MAU_UNALIGNED_EN
        applyStimulus(0, 2'b01, 0, 32'h31, 32'h0, "ld_half_31", 32'h00007F00, 0, 5);
`else
        applyStimulus(0, 2'b01, 0, 32'h31, 32'h0, "ld_half_31", 32'h0, 1, 1);
`endif
        applyStimulus(0, 2'b01, 1, 32'h20, 32'h0, "ld_shalf_20", 32'hFFFFC3D4, 0, 5);
        applyStimulus(0, 2'b01, 0, 32'h22, 32'h0, "ld_uhalf_22", 32'h0000A1B2, 0, 5);
        applyStimulus(0, 2'b11, 0, 32'h20, 32'h0, "ld_size3", 32'h0, 1, 1);
`ifdef MAU_UNALIGNED_EN
        applyStimulus(0, 2'b10, 0, 32'h22, 32'h0, "ld_word_22", 32'h0000A1B2, 0, 9);
`else
        applyStimulus(0, 2'b10, 0, 32'h22, 32'h0, "ld_word_22", 32'h0, 1, 1);
`endif
        applyStimulus(1, 2'b00, 0, 32'hFFFFFFFF, 32'h0000005A, "st_byte_top", 32'h0, 0, 2);
        applyStimulus(1, 2'b01, 0, 32'hFFFFFFFE, 32'h0000BEEF, "st_half_top", 32'h0, 0, 3);
`ifdef MAU_UNALIGNED_EN
        applyStimulus(1, 2'b10, 0, 32'hFFFFFFFD, 32'h11223344, "st_word_wrap", 32'h0, 0, 5);
        applyStimulus(0, 2'b10, 0, 32'hFFFFFFFC, 32'h0, "ld_word_top", 32'h22334400, 0, 9);
        applyStimulus(0, 2'b00, 1, 32'h0, 32'h0, "ld_byte_0", 32'h00000011, 0, 3);
`else
        applyStimulus(1, 2'b10, 0, 32'hFFFFFFFD, 32'h11223344, "st_word_wrap", 32'h0, 1, 1);
        applyStimulus(0, 2'b10, 0, 32'hFFFFFFFC, 32'h0, "ld_word_top", 32'hBEEF0000, 0, 9);
        applyStimulus(0, 2'b00, 1, 32'h0, 32'h0, "ld_byte_0", 32'h00000000, 0, 3);
`endif
        applyStimulus(1, 2'b11, 0, 32'h20, 32'hFFFFFFFF, "st_size3", 32'h0, 1, 1);
        applyStimulus(0, 2'b10, 0, 32'h20, 32'h0, "ld_word_20b", 32'hA1B2C3D4, 0, 9);

        // Reset during the second capture cycle of a word load
        sendRequest(0, 2'b10, 0, 32'h20, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_mem_read", 32'(mem_read), 32'h0);
        checkOutput("midrst_mem_write", 32'(mem_write), 32'h0);
        checkOutput("midrst_ready", 32'(req_ready), 32'h0);
        checkOutput("midrst_resp_valid", 32'(resp_valid), 32'h0);
        checkOutput("midrst_mem_addr", mem_addr, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        checkOutput("release_ready", 32'(req_ready), 32'h0);
        applyStimulus(0, 2'b00, 0, 32'h30, 32'h0, "ld_after_rst", 32'h00000080, 0, 3);

        repeat (2) @(posedge clk);
        $display("[TB] %0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
